// File: rtl/noise_pkg.sv
// Shared definitions for the PSG noise generator and its receive-side tracker:
// tracker states, LFSR reset value and per-platform feedback tap sets.
package noise_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } tracker_state_e;

    // Generator seed: a single 1 in the MSB position.
    function automatic int unsigned lfsr_reset_value(input int unsigned lfsr_bits);
        return 32'd1 << (lfsr_bits - 1);
    endfunction

    localparam int SMS_LFSR_BITS   = 16;
    localparam int SMS_TAP0        = 0;
    localparam int SMS_TAP1        = 3;
    localparam int SG_LFSR_BITS    = 15;
    localparam int SG_TAP0         = 0;
    localparam int SG_TAP1         = 1;
    localparam int TANDY_LFSR_BITS = 15;
    localparam int TANDY_TAP0      = 0;
    localparam int TANDY_TAP1      = 4;

endpackage

// File: rtl/noise_lfsr_tracker_if.sv
// Sample stream and status bundle between a noise source and the LFSR tracker.
interface noise_lfsr_tracker_if #(
    parameter int LFSR_BITS = 15,
    parameter int ERR_BITS  = 8
);
    logic                 sample_valid;
    logic                 sample_bit;
    logic                 is_white_noise;
    logic                 restart;
    logic                 locked;
    logic                 bit_error;
    logic                 expected_bit;
    logic [ERR_BITS-1:0]  error_count;
    logic [LFSR_BITS-1:0] window;

    modport master (
        output sample_valid, sample_bit, is_white_noise, restart,
        input  locked, bit_error, expected_bit, error_count, window
    );

    modport slave (
        input  sample_valid, sample_bit, is_white_noise, restart,
        output locked, bit_error, expected_bit, error_count, window
    );
endinterface

// File: rtl/lfsr_feedback.sv
// Noise LFSR feedback bit: XOR of two taps for white noise, single tap for
// periodic noise. Shared by the generator and the tracker.
module lfsr_feedback #(
    parameter int LFSR_BITS = 15,
    parameter int LFSR_TAP0 = 0,
    parameter int LFSR_TAP1 = 1
) (
    input  logic [LFSR_BITS-1:0] state,
    input  logic                 white,
    output logic                 fb
);
    assign fb = white ? (state[LFSR_TAP0] ^ state[LFSR_TAP1]) : state[LFSR_TAP0];
endmodule

// File: rtl/noise_lfsr_tracker.sv
// Reconstructs the noise LFSR state from its serial output, then flywheels on
// its own prediction and counts/flags mismatching samples.
module noise_lfsr_tracker
    import noise_pkg::*;
#(
    parameter int LFSR_BITS      = 15,
    parameter int LFSR_TAP0      = 0,
    parameter int LFSR_TAP1      = 1,
    parameter int ERR_BITS       = 8,
    parameter int LOSS_THRESHOLD = 4
) (
    input logic                 clk,
    input logic                 reset_lfsr,
    noise_lfsr_tracker_if.slave trk
);
    localparam int FILL_W = $clog2(LFSR_BITS + 1);
    localparam int MISS_W = 4;

    tracker_state_e       state_q, state_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [LFSR_BITS-1:0] w_q, w_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic                 mode_q, mode_d;
    logic                 bit_error_q, bit_error_d;
    logic                 expected_q, expected_d;
    logic [ERR_BITS-1:0]  err_q, err_d;
    logic                 fb_now, fb_next;

    lfsr_feedback #(.LFSR_BITS(LFSR_BITS), .LFSR_TAP0(LFSR_TAP0), .LFSR_TAP1(LFSR_TAP1))
        u_fb_now (.state(w_q), .white(trk.is_white_noise), .fb(fb_now));

    lfsr_feedback #(.LFSR_BITS(LFSR_BITS), .LFSR_TAP0(LFSR_TAP0), .LFSR_TAP1(LFSR_TAP1))
        u_fb_next (.state(w_d), .white(trk.is_white_noise), .fb(fb_next));

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        w_d         = w_q;
        miss_d      = miss_q;
        err_d       = err_q;
        bit_error_d = 1'b0;
        mode_d      = trk.is_white_noise;

        // A mode change invalidates the predictor exactly like restart; the window is kept.
        if (trk.restart || (trk.is_white_noise != mode_q)) begin
            state_d = ACQUIRE;
            fill_d  = '0;
            miss_d  = '0;
        end else if (trk.sample_valid) begin
            if (state_q == ACQUIRE) begin
                w_d = {trk.sample_bit, w_q[LFSR_BITS-1:1]};
                if (fill_q != FILL_W'(LFSR_BITS)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                if ((fill_d == FILL_W'(LFSR_BITS)) && (w_d != '0)) begin
                    state_d = TRACK;
                    miss_d  = '0;
                end
            end else begin
                // Flywheel: shift in the prediction so one bad sample cannot corrupt the window.
                w_d = {fb_now, w_q[LFSR_BITS-1:1]};
                if (trk.sample_bit != fb_now) begin
                    bit_error_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + ERR_BITS'(1);
                    end
                    miss_d = miss_q + MISS_W'(1);
                    if (miss_d == MISS_W'(LOSS_THRESHOLD)) begin
                        state_d = ACQUIRE;
                        fill_d  = '0;
                        miss_d  = '0;
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end
    end

    assign expected_d = (state_d == TRACK) ? fb_next : 1'b0;

    always_ff @(posedge clk or posedge reset_lfsr) begin
        if (reset_lfsr) begin
            state_q     <= ACQUIRE;
            fill_q      <= '0;
            w_q         <= '0;
            miss_q      <= '0;
            mode_q      <= 1'b0;
            bit_error_q <= 1'b0;
            expected_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            w_q         <= w_d;
            miss_q      <= miss_d;
            mode_q      <= mode_d;
            bit_error_q <= bit_error_d;
            expected_q  <= expected_d;
            err_q       <= err_d;
        end
    end

    assign trk.locked       = (state_q == TRACK);
    assign trk.bit_error    = bit_error_q;
    assign trk.expected_bit = expected_q;
    assign trk.error_count  = err_q;
    assign trk.window       = w_q;
endmodule
